// File: rtl/text_ram_arbiter_if.sv
// Video read, host write and character-RAM signals around text_ram_arbiter.
// slave is the arbiter's view; master is the clients' and RAM's view.
interface text_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 7
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output vid_req, vid_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        input  vid_data, vid_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  vid_req, vid_addr, wr_valid, wr_addr, wr_data, ram_rdata,
        output vid_data, vid_valid, wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/text_ram_arbiter.sv
// Single-port character RAM owner: video reads have priority, host writes drain
// from a small FIFO in idle slots, and a whole-screen clear runs in idle slots.
module text_ram_arbiter #(
    parameter int unsigned       ADDR_W     = 12,
    parameter int unsigned       DATA_W     = 7,
    parameter int unsigned       NUM_CELLS  = 2400,
    parameter logic [DATA_W-1:0] CLR_CHAR   = DATA_W'(7'h20),
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    text_ram_arbiter_if.slave           bus,
    input  logic                        clr_start,
    output logic                        clr_busy,
    output logic                        clr_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned       PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned       CNT_W     = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);

    typedef enum logic {NORMAL, CLEAR} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
    wr_entry_t         fifo_mem [FIFO_DEPTH];
    wr_entry_t         head;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count_n;
    logic              push, pop, flush;
    logic              ready_en;
    logic              rd_s1, rd_s2;
    logic              ram_en_n, ram_we_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [DATA_W-1:0] ram_wdata_n;
    logic              clr_done_n;

    assign head     = fifo_mem[rd_ptr];
    assign clr_busy = (state == CLEAR);
    // ready_en keeps wr_ready low for the first cycle after reset releases
    assign bus.wr_ready = ready_en && !reset && (fifo_count < CNT_W'(FIFO_DEPTH))
                        && (state == NORMAL) && !clr_start;
    assign push = bus.wr_valid && bus.wr_ready;

    // Slot arbitration and next state
    always_comb begin
        state_n     = state;
        clr_cnt_n   = clr_cnt;
        ram_en_n    = 1'b0;
        ram_we_n    = 1'b0;
        ram_addr_n  = bus.ram_addr;
        ram_wdata_n = bus.ram_wdata;
        clr_done_n  = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;

        if (bus.vid_req) begin
            ram_en_n   = 1'b1;
            ram_addr_n = bus.vid_addr;
        end else if (state == CLEAR) begin
            ram_en_n    = 1'b1;
            ram_we_n    = 1'b1;
            ram_addr_n  = clr_cnt;
            ram_wdata_n = CLR_CHAR;
            if (clr_cnt == LAST_CELL) begin
                clr_cnt_n  = '0;
                state_n    = NORMAL;
                clr_done_n = 1'b1;
            end else begin
                clr_cnt_n = clr_cnt + ADDR_W'(1);
            end
        end else if (fifo_count != '0) begin
            pop         = 1'b1;
            ram_en_n    = 1'b1;
            ram_we_n    = 1'b1;
            ram_addr_n  = head.addr;
            ram_wdata_n = head.data;
        end

        // Entries still queued when a clear starts are dropped
        if (state == NORMAL && clr_start) begin
            state_n   = CLEAR;
            clr_cnt_n = '0;
            flush     = 1'b1;
        end

        count_n = flush ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= NORMAL;
            clr_cnt       <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
            ready_en      <= 1'b0;
            rd_s1         <= 1'b0;
            rd_s2         <= 1'b0;
            bus.vid_valid <= 1'b0;
            bus.vid_data  <= '0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            clr_done      <= 1'b0;
        end else begin
            state         <= state_n;
            clr_cnt       <= clr_cnt_n;
            fifo_count    <= count_n;
            ready_en      <= 1'b1;
            rd_s1         <= bus.vid_req;
            rd_s2         <= rd_s1;
            bus.vid_valid <= rd_s2;
            if (rd_s2) bus.vid_data <= bus.ram_rdata;
            bus.ram_en    <= ram_en_n;
            bus.ram_we    <= ram_we_n;
            bus.ram_addr  <= ram_addr_n;
            bus.ram_wdata <= ram_wdata_n;
            clr_done      <= clr_done_n;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: bus.wr_addr, data: bus.wr_data};
    end
endmodule

// File: tb/tb_text_ram_arbiter.sv
// Randomised bench for text_ram_arbiter: a queue-based reference model predicts
// every RAM slot and video read; a monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_text_ram_arbiter;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 7;
    localparam int unsigned NUM_CELLS  = 2400;
    localparam int unsigned FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr_start = 1'b0;
    logic       clr_busy, clr_done;
    logic [2:0] fifo_count;

    text_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    text_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CELLS(NUM_CELLS),
        .CLR_CHAR(7'h20), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .clr_start(clr_start),
        .clr_busy(clr_busy), .clr_done(clr_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] init_val(input int i);
        return (i >= 10 && i <= 13) ? 7'(65 + i - 10) : 7'h00;
    endfunction

    // Character RAM: reloaded while reset is high, one-cycle read latency
    logic [6:0] ram [4096];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
        end else if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= ram[bus.ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic en; logic we; logic [11:0] addr; logic [6:0] data;} slot_t;
    typedef struct {int cyc; logic [6:0] data;} rd_t;
    typedef struct {logic [11:0] a; logic [6:0] d;} w_t;

    slot_t slot_q[$];
    rd_t   rd_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    logic [6:0] mem_m [4096];
    w_t         fifo_m[$];
    bit         clearing = 0;
    int         ccnt = 0;
    bit         alive = 0;
    bit         done_m = 0;
    bit         have_exp = 0;

    task automatic step(input bit rst, input bit vreq, input logic [11:0] vaddr,
                        input bit wv, input logic [11:0] wa, input logic [6:0] wd,
                        input bit cs, output bit acc);
        bit    ready;
        bit    was_clearing;
        slot_t s;
        w_t    w;
        int    e;
        @(negedge clk);
        if (have_exp) begin
            chk("fifo_count", fifo_count == 3'(fifo_m.size()), 32'(fifo_count), 32'(fifo_m.size()));
            chk("clr_busy", clr_busy == clearing, 32'(clr_busy), 32'(clearing));
            chk("clr_done", clr_done == done_m, 32'(clr_done), 32'(done_m));
        end
        reset = rst;  clr_start = cs;
        bus.vid_req = vreq;  bus.vid_addr = vaddr;
        bus.wr_valid = wv;   bus.wr_addr = wa;  bus.wr_data = wd;
        #1;
        e = cyc + 1;
        ready = !rst && alive && (fifo_m.size() < FIFO_DEPTH) && !clearing && !cs;
        chk("wr_ready", bus.wr_ready == ready, 32'(bus.wr_ready), 32'(ready));
        acc = wv && ready;
        s = '{cyc: e, en: 1'b0, we: 1'b0, addr: 12'h0, data: 7'h0};
        done_m = 0;
        was_clearing = clearing;
        if (rst) begin
            fifo_m.delete();
            clearing = 0;
            ccnt = 0;
            alive = 0;
            for (int i = 0; i < 4096; i++) mem_m[i] = init_val(i);
            while (rd_q.size() > 0 && rd_q[$].cyc >= e) void'(rd_q.pop_back());
        end else begin
            if (vreq) begin
                s.en = 1; s.addr = vaddr;
                rd_q.push_back('{cyc: e + 2, data: mem_m[vaddr]});
            end else if (clearing) begin
                s.en = 1; s.we = 1; s.addr = 12'(ccnt); s.data = 7'h20;
                mem_m[ccnt] = 7'h20;
                if (ccnt == NUM_CELLS - 1) begin
                    clearing = 0; ccnt = 0; done_m = 1;
                end else begin
                    ccnt++;
                end
            end else if (fifo_m.size() > 0) begin
                w = fifo_m.pop_front();
                s.en = 1; s.we = 1; s.addr = w.a; s.data = w.d;
                mem_m[w.a] = w.d;
            end
            if (cs && !was_clearing) begin
                fifo_m.delete();
                clearing = 1;
                ccnt = 0;
            end
            if (acc) fifo_m.push_back('{a: wa, d: wd});
            alive = 1;
        end
        slot_q.push_back(s);
        have_exp = 1;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(0, 0, 12'h0, 0, 12'h0, 7'h0, 0, acc);
    endtask

    function automatic logic [11:0] raddr();
        return 12'($urandom_range(0, NUM_CELLS - 1));
    endfunction

    // Monitor: pops the expectation for each edge and compares the DUT outputs
    initial begin
        slot_t s;
        rd_t   r;
        forever begin
            @(negedge clk);
            if (slot_q.size() > 0 && slot_q[0].cyc == cyc) begin
                s = slot_q.pop_front();
                if (s.en)
                    chk("ram_slot",
                        bus.ram_en && bus.ram_we == s.we && bus.ram_addr == s.addr &&
                        (!s.we || bus.ram_wdata == s.data),
                        32'({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}),
                        32'({s.en, s.we, s.addr, s.data}));
                else
                    chk("ram_idle", !bus.ram_en && !bus.ram_we,
                        32'({bus.ram_en, bus.ram_we}), 32'(0));
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                r = rd_q.pop_front();
                chk("vid_read", bus.vid_valid && bus.vid_data == r.data,
                    32'({bus.vid_valid, bus.vid_data}), 32'({1'b1, r.data}));
            end else if (have_exp) begin
                chk("vid_valid_idle", !bus.vid_valid, 32'(bus.vid_valid), 32'(0));
            end
        end
    end

    initial begin
        bit acc;
        int budget;
        int pushed;
        bit vtog;

        bus.vid_req = 0; bus.vid_addr = '0; bus.wr_valid = 0;
        bus.wr_addr = '0; bus.wr_data = '0;

        // Reset, then idle; register contents straight after reset
        repeat (3) step(1, 0, 12'h0, 0, 12'h0, 7'h0, 0, acc);
        idle(1);
        chk("rst_ram_addr", bus.ram_addr == 12'h0, 32'(bus.ram_addr), 32'(0));
        chk("rst_ram_wdata", bus.ram_wdata == 7'h0, 32'(bus.ram_wdata), 32'(0));
        chk("rst_vid_data", bus.vid_data == 7'h0, 32'(bus.vid_data), 32'(0));
        idle(3);

        // Back-to-back video reads of the preloaded 'A'..'D'
        for (int i = 0; i < 4; i++) step(0, 1, 12'(10 + i), 0, 12'h0, 7'h0, 0, acc);
        idle(4);

        // Five host writes, each held until accepted, then read back
        for (int i = 0; i < 5; i++) begin
            budget = 0;
            do begin
                step(0, 0, 12'h0, 1, 12'(5 + i), 7'(8'h30 + i), 0, acc);
                budget++;
            end while (!acc && budget < 20);
            if (!acc) chk("push_timeout", 0, 32'(budget), 32'(20));
        end
        idle(4);
        for (int i = 0; i < 5; i++) step(0, 1, 12'(5 + i), 0, 12'h0, 7'h0, 0, acc);
        idle(4);

        // FIFO fills while video holds every slot for 100 cycles
        pushed = 0;
        for (int c = 0; c < 100; c++) begin
            step(0, 1, raddr(), pushed < 4, 12'(100 + pushed), 7'(8'h50 + pushed), 0, acc);
            if (acc) pushed++;
        end
        idle(6);
        for (int i = 0; i < 4; i++) step(0, 1, 12'(100 + i), 0, 12'h0, 7'h0, 0, acc);
        idle(4);

        // Clear with two FIFO entries pending, video alternating
        for (int i = 0; i < 2; i++) step(0, 1, raddr(), 1, 12'(200 + i), 7'h11, 0, acc);
        step(0, 1, raddr(), 1, 12'h300, 7'h22, 1, acc);
        vtog = 0;
        budget = 0;
        while (clearing && budget < 6000) begin
            step(0, vtog, raddr(), 1'($urandom_range(0, 1)), raddr(), 7'($urandom), 0, acc);
            vtog = !vtog;
            budget++;
        end
        if (clearing) chk("clear_timeout", 0, 32'(ccnt), 32'(NUM_CELLS));
        idle(4);

        // Reset part way through a clear, then a full clear from address 0
        step(0, 0, 12'h0, 0, 12'h0, 7'h0, 1, acc);
        budget = 0;
        while (ccnt < 1000 && budget < 3000) begin
            step(0, 1'($urandom_range(0, 1)), raddr(), 0, 12'h0, 7'h0, 0, acc);
            budget++;
        end
        idle(3);
        repeat (2) step(1, 0, 12'h0, 0, 12'h0, 7'h0, 0, acc);
        idle(3);
        step(0, 0, 12'h0, 0, 12'h0, 7'h0, 1, acc);
        budget = 0;
        while (clearing && budget < 6000) begin
            step(0, 1'($urandom_range(0, 1)), raddr(), 1'($urandom_range(0, 1)),
                 raddr(), 7'($urandom), 0, acc);
            budget++;
        end
        if (clearing) chk("clear2_timeout", 0, 32'(ccnt), 32'(NUM_CELLS));
        idle(3);

        // Random mix of reads, writes and occasional clears
        for (int c = 0; c < 1500; c++)
            step(0, $urandom_range(0, 99) < 50, raddr(), 1'($urandom_range(0, 1)),
                 raddr(), 7'($urandom), $urandom_range(0, 599) == 0, acc);
        idle(6);
        repeat (3) @(negedge clk);
        #2;
        chk("slot_q_drained", slot_q.size() == 0, 32'(slot_q.size()), 32'(0));
        chk("rd_q_drained", rd_q.size() == 0, 32'(rd_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
